uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: number of baud_tick pulses per bit period.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of flops in the serial input synchronizer.
REQ-003 SHALL have port clk, input, 1: the system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low global reset.
REQ-005 SHALL have port baud_tick, input, 1: one-clk pulse at OVERSAMPLE times the baud rate, produced by the clock divider.
REQ-006 SHALL have port serial_data_in, input, 1: asynchronous UART line, idle high.
REQ-007 SHALL have port rx_en, input, 1: receiver enable.
REQ-008 SHALL have port data_length, input, 2: data bits per frame; 00=5, 01=6, 10=7, 11=8.
REQ-009 SHALL have port parity_en, input, 1: a parity bit follows the data bits.
REQ-010 SHALL have port parity_even, input, 1: 1 selects even parity, 0 selects odd parity.
REQ-011 SHALL have port stop_bits, input, 1: 0 selects one stop bit, 1 selects two stop bits.
REQ-012 SHALL have port data_ready, input, 1: the consumer accepts the held word.
REQ-013 SHALL have port data_out, output, 8: the received word, LSB-aligned, with unused upper bits set to 0.
REQ-014 SHALL have port data_valid, output, 1: data_out, frame_err, parity_err and break_det are valid.
REQ-015 SHALL have ports frame_err, parity_err and break_det, output, 1 each: status bits attached to the held word.
REQ-016 SHALL have port overrun_err, output, 1: one-clk pulse indicating a completed frame was dropped.
REQ-017 SHALL have port busy, output, 1: the receiver is in any state other than IDLE.

Function
REQ-018 SHALL pass serial_data_in through SYNC_STAGES flops, preset to 1; all decisions SHALL use the synchronized value rxs.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2 and WAIT_HIGH; a tick counter SHALL advance only on baud_tick.
REQ-020 IDLE: when rx_en=1 and rxs=0, SHALL latch data_length, parity_en, parity_even and stop_bits, clear the tick counter, and enter START.
REQ-021 START: after OVERSAMPLE/2 ticks, SHALL sample rxs; if rxs=1, treat it as a false start and return to IDLE with no output; otherwise enter DATA.
REQ-022 DATA/PARITY/STOP1/STOP2: SHALL sample each bit every OVERSAMPLE ticks after the previous sample, at the bit midpoint; data bits SHALL be taken LSB first.
REQ-023 After the last data bit, SHALL enter PARITY if parity_en=1, else STOP1; SHALL enter STOP2 from STOP1 only if stop_bits=1.
REQ-024 Parity check: SHALL set parity_err=1 when (XOR of data bits) XOR parity bit XOR ~parity_even equals 1.
REQ-025 Framing check: SHALL set frame_err=1 if any sampled stop bit is 0.
REQ-026 Break check: SHALL set break_det=1 when all data bits, the parity bit (if enabled) and the stop bit are all 0.
REQ-027 Frame completion: SHALL occur at the final stop sample; data_valid SHALL assert on the next clk.
REQ-028 On completion, SHALL enter IDLE if every stop sample was 1; otherwise SHALL enter WAIT_HIGH, which exits to IDLE on rxs=1.
REQ-029 Handshake: the word is consumed on a clk where data_valid=1 and data_ready=1; the output register SHALL hold all its fields stable until the word is consumed.
REQ-030 Overrun: if a frame completes while data_valid=1 and data_ready=0, SHALL pulse overrun_err for 1 clk, discard the new frame and keep the old word.
REQ-031 If completion coincides with data_valid=1 and data_ready=1, SHALL load the new word, keep data_valid=1, and not raise overrun_err.
REQ-032 If rx_en deasserts mid-frame, SHALL return to IDLE on the next clk with no output and no error; a word already held SHALL be unaffected.
REQ-033 SHALL treat configuration input changes mid-frame as having no effect until the next start.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, counters to 0, synchronizer flops to 1, data_out=0x00, and data_valid, frame_err, parity_err, break_det, overrun_err and busy to 0.
REQ-035 Reset deassertion SHALL take effect on a clk edge; the first possible start detect SHALL be on the clk after release.

Verification
REQ-036 8N1 frame, 0xA5, baud_tick every 4 clk -> data_out=0xA5, data_valid=1, all error bits 0; busy=0 after completion.
REQ-037 7E1 frame, 0x35, correct parity bit 0, then the same frame with parity bit 1 -> first word has parity_err=0; second word has data_out=0x35 and parity_err=1.
REQ-038 Low glitch of 5 ticks on the line -> false start, no data_valid, back to IDLE; then 5N2 frame 0x1F with second stop bit 0 -> data_out=0x1F, frame_err=1.
REQ-039 Line held low for 2 frame times with 8N1 -> data_out=0x00, break_det=1, frame_err=1; no new start until the line returns high.
REQ-040 Two 8N1 frames 0x11 then 0x22 with data_ready=0 -> overrun_err pulses once, data_out stays 0x11; repeat with data_ready=1 on the completion clk -> data_out=0x22, no overrun.
REQ-041 rst=0 mid-DATA, and separately rx_en=0 mid-DATA -> IDLE, no data_valid; a following 8N1 frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx_core: line, baud tick, frame configuration,
// word handshake and status. The core takes the slave modport.
interface uart_rx_if;
  logic       baud_tick;
  logic       serial_data_in;
  logic       rx_en;
  logic [1:0] data_length;
  logic       parity_en;
  logic       parity_even;
  logic       stop_bits;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       break_det;
  logic       overrun_err;
  logic       busy;

  modport slave (
    input  baud_tick, serial_data_in, rx_en, data_length, parity_en,
           parity_even, stop_bits, data_ready,
    output data_out, data_valid, frame_err, parity_err, break_det,
           overrun_err, busy
  );

  modport master (
    output baud_tick, serial_data_in, rx_en, data_length, parity_en,
           parity_even, stop_bits, data_ready,
    input  data_out, data_valid, frame_err, parity_err, break_det,
           overrun_err, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchronizes the line, samples mid-bit on baud
// ticks and presents one held word with status under a valid/ready handshake.
module uart_rx_core #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          par_q, par_d, zero_q, zero_d;
  logic          ferr_q, ferr_d, perr_q, perr_d, brk_q, brk_d;
  logic [1:0]    len_q, len_d;
  logic          pen_q, pen_d, peven_q, peven_d, stop2_q, stop2_d;
  logic          samp, done;
  logic [2:0]    last_bit;

  logic [7:0]    dout_q;
  logic          dv_q, oferr_q, operr_q, obrk_q, ovr_q;

  // Line synchronizer; presets to idle-high so reset never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx.serial_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      par_q   <= 1'b0;
      zero_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      brk_q   <= 1'b0;
      len_q   <= '0;
      pen_q   <= 1'b0;
      peven_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      par_q   <= par_d;
      zero_q  <= zero_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      brk_q   <= brk_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      peven_q <= peven_d;
      stop2_q <= stop2_d;
    end
  end

  assign last_bit = 3'd4 + {1'b0, len_q};
  // START waits half a bit to land on the start-bit midpoint; later bits a full bit.
  assign samp = rx.baud_tick &&
                (cnt_q == ((state_q == S_START) ? HALF_M1 : FULL_M1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    par_d   = par_q;
    zero_d  = zero_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    brk_d   = brk_q;
    len_d   = len_q;
    pen_d   = pen_q;
    peven_d = peven_q;
    stop2_d = stop2_q;
    done    = 1'b0;

    if (rx.baud_tick && state_q != S_IDLE && state_q != S_WAIT_HIGH)
      cnt_d = samp ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: if (rx.rx_en && !rxs) begin
        len_d   = rx.data_length;
        pen_d   = rx.parity_en;
        peven_d = rx.parity_even;
        stop2_d = rx.stop_bits;
        cnt_d   = '0;
        bit_d   = '0;
        shf_d   = '0;
        par_d   = 1'b0;
        zero_d  = 1'b1;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        brk_d   = 1'b0;
        state_d = S_START;
      end
      S_START: if (samp) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA: if (samp) begin
        shf_d[bit_q] = rxs;
        par_d  = par_q ^ rxs;
        zero_d = zero_q & ~rxs;
        if (bit_q == last_bit) state_d = pen_q ? S_PARITY : S_STOP1;
        else                   bit_d   = bit_q + 3'd1;
      end
      S_PARITY: if (samp) begin
        perr_d  = par_q ^ rxs ^ ~peven_q;
        zero_d  = zero_q & ~rxs;
        state_d = S_STOP1;
      end
      S_STOP1: if (samp) begin
        ferr_d = ~rxs;
        brk_d  = zero_q & ~rxs;
        if (stop2_q) begin
          state_d = S_STOP2;
        end else begin
          done    = 1'b1;
          state_d = rxs ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_STOP2: if (samp) begin
        ferr_d  = ferr_q | ~rxs;
        done    = 1'b1;
        state_d = (ferr_q | ~rxs) ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Disabling aborts the frame silently; the held word is untouched.
    if (!rx.rx_en && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done    = 1'b0;
    end
  end

  // Output word register: a completed frame is dropped only when the old word
  // is still held and not being consumed on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q  <= '0;
      dv_q    <= 1'b0;
      oferr_q <= 1'b0;
      operr_q <= 1'b0;
      obrk_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= done && dv_q && !rx.data_ready;
      if (done && (!dv_q || rx.data_ready)) begin
        dout_q  <= shf_q;
        oferr_q <= ferr_d;
        operr_q <= perr_d;
        obrk_q  <= brk_d;
        dv_q    <= 1'b1;
      end else if (dv_q && rx.data_ready) begin
        dv_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rx.busy        = (state_q != S_IDLE);
    rx.data_out    = dout_q;
    rx.data_valid  = dv_q;
    rx.frame_err   = oferr_q;
    rx.parity_err  = operr_q;
    rx.break_det   = obrk_q;
    rx.overrun_err = ovr_q;
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: expected words are queued as frames are
// sent; a monitor pops and compares each word as it is consumed.
module tb_uart_rx_core;

  localparam int BIT = 64;  // 16 ticks x 4 clk

  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  uart_rx_if rx();

  uart_rx_core #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       p;
    logic       b;
  } exp_t;

  exp_t q[$];
  exp_t e_mon, g_mon;
  int   total = 0;
  int   bad   = 0;
  int   ovr_cnt = 0;
  int   ovr_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Baud tick: one clk high every 4 clk, changed just after posedge.
  initial begin
    rx.baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 rx.baud_tick = 1'b1;
      @(posedge clk);
      #1 rx.baud_tick = 1'b0;
    end
  end

  // Monitor: samples between edges, compares every consumed word.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      if (rx.overrun_err) ovr_cnt++;
      if (rx.data_valid && rx.data_ready) begin
        total++;
        g_mon = {rx.data_out, rx.frame_err, rx.parity_err, rx.break_det};
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got d=%0h f=%0b p=%0b b=%0b, none expected",
                   g_mon.d, g_mon.f, g_mon.p, g_mon.b);
        end else begin
          e_mon = q.pop_front();
          if (g_mon !== e_mon) begin
            bad++;
            $display("FAIL word: got d=%0h f=%0b p=%0b b=%0b want d=%0h f=%0b p=%0b b=%0b",
                     g_mon.d, g_mon.f, g_mon.p, g_mon.b, e_mon.d, e_mon.f, e_mon.p, e_mon.b);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1);
  end

  task automatic line(input logic v, input int clks);
    rx.serial_data_in = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] len, input logic pen, input logic peven, input logic s2);
    rx.data_length = len;
    rx.parity_en   = pen;
    rx.parity_even = peven;
    rx.stop_bits   = s2;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pbit, input int nstop, input logic s2);
    line(1'b0, BIT);
    for (int i = 0; i < nb; i++) line(d[i], BIT);
    if (pen) line(pbit, BIT);
    line(1'b1, BIT);
    if (nstop == 2) line(s2, BIT);
    line(1'b1, BIT);
  endtask

  // Raise data_ready only for the edge where the frame's final stop sample lands.
  task automatic ready_at_completion(input int n);
    int g;
    int c;
    g = 0;
    c = 0;
    while (!rx.busy && g < 2000) begin
      @(negedge clk);
      g++;
    end
    while (g < 4000) begin
      if (rx.busy && rx.baud_tick) begin
        c++;
        if (c == n) break;
      end
      @(negedge clk);
      g++;
    end
    total++;
    if (c != n) begin
      bad++;
      $display("FAIL completion_wait: counted %0d ticks, needed %0d", c, n);
    end
    rx.data_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rx.serial_data_in = 1'b1;
    rx.rx_en          = 1'b1;
    rx.data_ready     = 1'b1;
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("rst_data_out",   rx.data_out,    8'h00);
    chk("rst_data_valid", rx.data_valid,  1'b0);
    chk("rst_frame_err",  rx.frame_err,   1'b0);
    chk("rst_parity_err", rx.parity_err,  1'b0);
    chk("rst_break_det",  rx.break_det,   1'b0);
    chk("rst_overrun",    rx.overrun_err, 1'b0);
    chk("rst_busy",       rx.busy,        1'b0);
    rst = 1'b1;
    line(1'b1, BIT);

    // 8N1 0xA5
    q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("8n1_busy_after", rx.busy, 1'b0);

    // 7E1 0x35 (four ones): parity 0 is good, parity 1 is bad
    cfg(2'b10, 1'b1, 1'b1, 1'b0);
    q.push_back('{8'h35, 1'b0, 1'b0, 1'b0});
    send_frame(8'h35, 7, 1'b1, 1'b0, 1, 1'b1);
    q.push_back('{8'h35, 1'b0, 1'b1, 1'b0});
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1);

    // 5-tick low glitch: false start
    cfg(2'b00, 1'b0, 1'b0, 1'b1);
    line(1'b0, 20);
    line(1'b1, 2*BIT);
    chk("glitch_busy", rx.busy, 1'b0);
    chk("glitch_no_valid", rx.data_valid, 1'b0);

    // 5N2 0x1F with second stop bit 0
    q.push_back('{8'h1F, 1'b1, 1'b0, 1'b0});
    send_frame(8'h1F, 5, 1'b0, 1'b0, 2, 1'b0);
    chk("5n2_busy_after", rx.busy, 1'b0);

    // Break: 8N1 line low for two frame times
    cfg(2'b11, 1'b0, 1'b0, 1'b0);
    q.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
    line(1'b0, 20*BIT);
    chk("break_wait_high_busy", rx.busy, 1'b1);
    line(1'b1, 2*BIT);
    chk("break_busy_after", rx.busy, 1'b0);

    // Overrun: 0x11 then 0x22 with data_ready low
    rx.data_ready = 1'b0;
    ovr_base = ovr_cnt;
    q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("overrun_pulses", ovr_cnt - ovr_base, 1);
    chk("overrun_held_data", rx.data_out, 8'h11);
    chk("overrun_held_valid", rx.data_valid, 1'b1);
    rx.data_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("overrun_consumed", rx.data_valid, 1'b0);

    // Completion coincides with consume: no overrun, new word replaces old
    rx.data_ready = 1'b0;
    ovr_base = ovr_cnt;
    q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    q.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
    fork
      send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
      ready_at_completion(152);
    join
    chk("coincide_no_overrun", ovr_cnt - ovr_base, 0);
    chk("coincide_drained", rx.data_valid, 1'b0);

    // Reset mid-DATA
    line(1'b0, 3*BIT);
    chk("rst_abort_busy_before", rx.busy, 1'b1);
    rx.serial_data_in = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_abort_busy", rx.busy, 1'b0);
    rst = 1'b1;
    line(1'b1, 2*BIT);
    chk("rst_abort_idle", rx.busy, 1'b0);
    chk("rst_abort_no_valid", rx.data_valid, 1'b0);

    // rx_en drop mid-DATA
    line(1'b0, 3*BIT);
    chk("en_abort_busy_before", rx.busy, 1'b1);
    rx.rx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_abort_busy", rx.busy, 1'b0);
    rx.serial_data_in = 1'b1;
    line(1'b1, 2*BIT);
    chk("en_abort_no_valid", rx.data_valid, 1'b0);
    rx.rx_en = 1'b1;
    line(1'b1, BIT);

    // Recovery frame 0x5A
    q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
